// File: rtl/secure_mode_pkg.sv
// Shared types for the secure mode FSM: state and command encodings plus
// the parity helper that protects the state register.
package secure_mode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_LOCKED = 2'b10,
    ST_RSVD   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_ENTER  = 2'b01,
    OP_EXIT   = 2'b10,
    OP_UNLOCK = 2'b11
  } op_t;

  // Even parity: state bits plus this bit always hold an even number of ones.
  function automatic logic state_par(state_t s);
    return ^s;
  endfunction

endpackage

// File: rtl/smf_watchdog.sv
// Inactivity counter for the ACTIVE state; expire_o fires on the cycle that
// would take the count to TIMEOUT, and the count then restarts from zero.
module smf_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An accepted command in the expiry cycle wins, so clear masks the expire.
  assign expire_o = enable && !clear && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!enable || clear || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/secure_mode_fsm.sv
// Command-driven mode FSM with illegal-command lockout, keyed unlock,
// inactivity watchdog and a parity-protected state register.
module secure_mode_fsm
  import secure_mode_pkg::*;
#(
  parameter int              N_MODES    = 4,
  parameter int              MODE_W     = 4,
  parameter int              MAX_ERR    = 3,
  parameter int              TIMEOUT    = 16,
  parameter int              COOLDOWN   = 2,
  parameter logic [MODE_W-1:0] UNLOCK_KEY = 'h5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [MODE_W-1:0] cmd_arg,
  output logic [1:0]        state_o,
  output logic [MODE_W-1:0] mode_o,
  output logic [7:0]        err_cnt_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic              fault_o
);

  localparam int COOL_W = $clog2(COOLDOWN + 1);

  state_t              state_q, state_d;
  logic                par_q, par_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                err_q, err_d;
  logic                timeout_q, timeout_d;
  logic                fault_q, fault_d;
  logic [COOL_W-1:0]   cool_q, cool_d;

  logic   accept;
  logic   corrupt;
  logic   arg_ok;
  logic   illegal;
  logic   wd_expire;
  logic [7:0] err_inc;
  op_t    op;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (cool_q == '0);
  assign accept    = cmd_valid && cmd_ready;
  assign corrupt   = (par_q != state_par(state_q)) || (state_q == ST_RSVD);
  assign arg_ok    = (32'(cmd_arg) < N_MODES);
  assign err_inc   = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  smf_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   ((state_q == ST_ACTIVE) && !corrupt),
    .clear    (accept),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    fault_d   = 1'b0;
    illegal   = 1'b0;
    cool_d    = (cool_q != '0) ? cool_q - COOL_W'(1) : '0;

    // A corrupted state register overrides and discards any accepted command.
    if (corrupt) begin
      state_d = ST_LOCKED;
      mode_d  = '0;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_ENTER: begin
                if (arg_ok) begin
                  state_d = ST_ACTIVE;
                  mode_d  = cmd_arg;
                end else begin
                  illegal = 1'b1;
                end
              end
              OP_UNLOCK:      illegal = 1'b1;
              OP_NOP, OP_EXIT: ;
            endcase
          end
        end
        ST_ACTIVE: begin
          if (accept) begin
            case (op)
              OP_ENTER: begin
                if (arg_ok) mode_d  = cmd_arg;
                else        illegal = 1'b1;
              end
              OP_EXIT: begin
                state_d = ST_IDLE;
                mode_d  = '0;
              end
              OP_UNLOCK: illegal = 1'b1;
              OP_NOP:    ;
            endcase
          end else if (wd_expire) begin
            state_d   = ST_IDLE;
            mode_d    = '0;
            timeout_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (accept && op != OP_NOP) begin
            if (op == OP_UNLOCK && cmd_arg == UNLOCK_KEY) begin
              state_d   = ST_IDLE;
              err_cnt_d = '0;
            end else begin
              illegal = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_LOCKED;
          mode_d  = '0;
        end
      endcase

      if (illegal) begin
        err_d     = 1'b1;
        err_cnt_d = err_inc;
        cool_d    = COOL_W'(COOLDOWN);
        if (32'(err_inc) >= MAX_ERR) begin
          state_d = ST_LOCKED;
          mode_d  = '0;
        end
      end
    end
  end

  assign par_d = state_par(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      par_q     <= 1'b0;
      mode_q    <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
      cool_q    <= '0;
    end else begin
      state_q   <= state_d;
      par_q     <= par_d;
      mode_q    <= mode_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
      cool_q    <= cool_d;
    end
  end

  assign state_o   = state_q;
  assign mode_o    = mode_q;
  assign err_cnt_o = err_cnt_q;
  assign err_o     = err_q;
  assign timeout_o = timeout_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_secure_mode_fsm.sv
// Directed self-checking bench for secure_mode_fsm with default parameters.
module tb_secure_mode_fsm;
  import secure_mode_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [1:0] state_o;
  logic [3:0] mode_o;
  logic [7:0] err_cnt_o;
  logic       err_o;
  logic       timeout_o;
  logic       fault_o;

  int checks;
  int errors;

  secure_mode_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .state_o   (state_o),
    .mode_o    (mode_o),
    .err_cnt_o (err_cnt_o),
    .err_o     (err_o),
    .timeout_o (timeout_o),
    .fault_o   (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one command for exactly one rising edge, then sample 1ns later.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 4'd0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 4'd0;

    #12;
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_mode", mode_o, 0);
    checkOutput("rst_errcnt", err_cnt_o, 0);
    checkOutput("rst_pulses", {err_o, timeout_o, fault_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_state_after", state_o, 0);

    applyStimulus(OP_ENTER, 4'd2);
    checkOutput("enter2_state", state_o, 1);
    checkOutput("enter2_mode", mode_o, 2);
    applyStimulus(OP_EXIT, 4'd0);
    checkOutput("exit_state", state_o, 0);
    checkOutput("exit_mode", mode_o, 0);

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(OP_ENTER, 4'd9);
      checkOutput("bad_enter_err", err_o, 1);
      checkOutput("bad_enter_cnt", err_cnt_o, i);
      checkOutput("bad_enter_ready0", cmd_ready, 0);
      checkOutput("bad_enter_state", state_o, (i < 3) ? 0 : 2);
      idleCycles(1);
      checkOutput("bad_enter_errpulse", err_o, 0);
      checkOutput("bad_enter_ready1", cmd_ready, 0);
      idleCycles(1);
      checkOutput("bad_enter_ready2", cmd_ready, 1);
    end

    applyStimulus(OP_UNLOCK, 4'd4);
    checkOutput("badkey_err", err_o, 1);
    checkOutput("badkey_state", state_o, 2);
    checkOutput("badkey_cnt", err_cnt_o, 4);
    idleCycles(2);
    applyStimulus(OP_UNLOCK, 4'd5);
    checkOutput("unlock_state", state_o, 0);
    checkOutput("unlock_cnt", err_cnt_o, 0);
    checkOutput("unlock_err", err_o, 0);

    applyStimulus(OP_ENTER, 4'd1);
    checkOutput("wd_enter_mode", mode_o, 1);
    idleCycles(15);
    checkOutput("wd_15_state", state_o, 1);
    checkOutput("wd_15_tmo", timeout_o, 0);
    idleCycles(1);
    checkOutput("wd_16_state", state_o, 0);
    checkOutput("wd_16_tmo", timeout_o, 1);
    checkOutput("wd_16_mode", mode_o, 0);
    idleCycles(1);
    checkOutput("wd_tmo_pulse", timeout_o, 0);

    applyStimulus(OP_ENTER, 4'd1);
    idleCycles(14);
    applyStimulus(OP_NOP, 4'd0);
    checkOutput("nop_state", state_o, 1);
    idleCycles(1);
    checkOutput("nop_16_tmo", timeout_o, 0);
    checkOutput("nop_16_state", state_o, 1);
    idleCycles(14);
    checkOutput("nop_30_state", state_o, 1);
    idleCycles(1);
    checkOutput("nop_31_tmo", timeout_o, 1);
    checkOutput("nop_31_state", state_o, 0);

    applyStimulus(OP_ENTER, 4'd1);
    applyStimulus(OP_ENTER, 4'd7);
    checkOutput("act_bad_err", err_o, 1);
    checkOutput("act_bad_state", state_o, 1);
    checkOutput("act_bad_mode", mode_o, 1);
    idleCycles(2);
    applyStimulus(OP_ENTER, 4'd3);
    checkOutput("act_reenter_mode", mode_o, 3);
    applyStimulus(OP_EXIT, 4'd0);
    checkOutput("act_exit_state", state_o, 0);

    @(negedge clk);
    force dut.state_q = ST_RSVD;
    #1;
    release dut.state_q;
    @(posedge clk);
    #1;
    checkOutput("fault_state", state_o, 2);
    checkOutput("fault_pulse", fault_o, 1);
    checkOutput("fault_cnt", err_cnt_o, 1);
    checkOutput("fault_mode", mode_o, 0);
    idleCycles(1);
    checkOutput("fault_pulse_end", fault_o, 0);

    applyStimulus(OP_ENTER, 4'd0);
    checkOutput("lock_cmd_cnt", err_cnt_o, 2);
    checkOutput("lock_cmd_ready", cmd_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_state", state_o, 0);
    checkOutput("async_cnt", err_cnt_o, 0);
    checkOutput("async_pulses", {err_o, timeout_o, fault_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1);
    checkOutput("post_rst_ready", cmd_ready, 1);
    applyStimulus(OP_ENTER, 4'd2);
    checkOutput("post_rst_enter", state_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
